// File: rtl/hex_word_tx_seq.sv
// Streams a binary word as uppercase ASCII hex over a valid/ready character
// interface, with an optional "0x" prefix and optional CR/LF terminator.

module hex2ascii_df (
  input  logic [3:0] nib_i,
  output logic [6:0] char_o
);
  // 0-9 map onto '0'..'9'; A-F map onto 'A'..'F' (0x41 = 0x37 + 10).
  assign char_o = (nib_i < 4'd10) ? (7'h30 + {3'b000, nib_i})
                                  : (7'h37 + {3'b000, nib_i});
endmodule

module hex_word_tx_seq #(
  parameter int NIBBLES = 4,
  parameter int PREFIX  = 1,
  parameter int EOL     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [6:0]             out_char,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PFX0,
    S_PFX1,
    S_DIG,
    S_CR,
    S_LF
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [6:0]    digit_char;
  logic          fire;

  hex2ascii_df u_hex2ascii (
    .nib_i  (shreg_q[W-1 -: 4]),
    .char_o (digit_char)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // in_ready is gated by rst so it reads 0 throughout reset, not just after.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q != S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign fire      = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    out_char = 7'h00;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          shreg_d = in_data;
          cnt_d   = '0;
          state_d = (PREFIX != 0) ? S_PFX0 : S_DIG;
        end
      end
      S_PFX0: begin
        out_char = 7'h30;
        if (fire) state_d = S_PFX1;
      end
      S_PFX1: begin
        out_char = 7'h78;
        if (fire) state_d = S_DIG;
      end
      S_DIG: begin
        out_char = digit_char;
        if (fire) begin
          shreg_d = shreg_q << 4;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = (EOL != 0) ? S_CR : S_IDLE;
        end
      end
      S_CR: begin
        out_char = 7'h0D;
        if (fire) state_d = S_LF;
      end
      S_LF: begin
        out_char = 7'h0A;
        if (fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hex_word_tx_seq.sv
// Directed, table-driven bench for hex_word_tx_seq (default config) plus a
// minimal NIBBLES=2/PREFIX=0/EOL=0 instance.

module tb_hex_word_tx_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_data;
  logic [6:0]  out_char;

  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_busy;
  logic [7:0]  m_in_data;
  logic [6:0]  m_out_char;

  int total = 0;
  int bad   = 0;
  logic [6:0] got[$];

  always #5 clk = ~clk;

  hex_word_tx_seq #(.NIBBLES(4), .PREFIX(1), .EOL(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_char(out_char), .busy(busy)
  );

  hex_word_tx_seq #(.NIBBLES(2), .PREFIX(0), .EOL(0)) dut_min (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_data(m_in_data), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_char(m_out_char), .busy(m_busy)
  );

  typedef struct {
    logic [15:0] data;
    bit          bp;
    bit          hold;
    logic [6:0]  exp [8];
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the last handshake.
  task automatic emit(input logic [15:0] w, input bit bp, input bit hold, input int n);
    int         cyc;
    bit         stalled;
    logic [6:0] prev;
    got.delete();
    stalled  = 0;
    prev     = '0;
    cyc      = 0;
    in_data  = w;
    in_valid = 1'b1;
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    while (cyc < 200 && got.size() < n) begin
      in_data   = 16'($urandom);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("valid_busy_nready", {29'd0, out_valid, busy, in_ready}, 32'b110);
      if (stalled) chk("stall_char", {25'd0, out_char}, {25'd0, prev});
      if (out_ready) begin
        got.push_back(out_char);
        stalled = 0;
      end else begin
        stalled = 1;
        prev    = out_char;
      end
      cyc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (got.size() < n) chk("timeout_chars", got.size(), n);
    if (!bp) chk("no_gap_cycles", cyc, n);
    chk("idle_after_last", {29'd0, out_valid, busy, in_ready}, 32'b001);
  endtask

  initial begin
    tbl[0] = '{16'h1A3F, 1'b0, 1'b0, '{7'h30, 7'h78, 7'h31, 7'h41, 7'h33, 7'h46, 7'h0D, 7'h0A}};
    tbl[1] = '{16'h9ABC, 1'b0, 1'b0, '{7'h30, 7'h78, 7'h39, 7'h41, 7'h42, 7'h43, 7'h0D, 7'h0A}};
    tbl[2] = '{16'h0000, 1'b0, 1'b0, '{7'h30, 7'h78, 7'h30, 7'h30, 7'h30, 7'h30, 7'h0D, 7'h0A}};
    tbl[3] = '{16'hFFFF, 1'b0, 1'b0, '{7'h30, 7'h78, 7'h46, 7'h46, 7'h46, 7'h46, 7'h0D, 7'h0A}};
    tbl[4] = '{16'h1A3F, 1'b1, 1'b0, '{7'h30, 7'h78, 7'h31, 7'h41, 7'h33, 7'h46, 7'h0D, 7'h0A}};
    tbl[5] = '{16'h1A3F, 1'b0, 1'b1, '{7'h30, 7'h78, 7'h31, 7'h41, 7'h33, 7'h46, 7'h0D, 7'h0A}};
    tbl[6] = '{16'h9ABC, 1'b0, 1'b0, '{7'h30, 7'h78, 7'h39, 7'h41, 7'h42, 7'h43, 7'h0D, 7'h0A}};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    m_in_valid = 1'b0; m_in_data = '0; m_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_char",  {25'd0, out_char},  32'h00);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Entry 5 holds in_valid high with changing data; entry 6 follows with no idle gap.
    for (int i = 0; i < 7; i++) begin
      emit(tbl[i].data, tbl[i].bp, tbl[i].hold, 8);
      for (int k = 0; k < 8; k++)
        if (k < got.size()) chk($sformatf("vec%0d_char%0d", i, k), {25'd0, got[k]}, {25'd0, tbl[i].exp[k]});
    end

    // Reset mid-word after three handshakes of 0x1234.
    in_data = 16'h1234; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_char_before_rst", {25'd0, out_char}, 32'h32);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy",      {31'd0, busy},      32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    emit(16'h00FF, 1'b0, 1'b0, 8);
    begin
      logic [6:0] e [8];
      e = '{7'h30, 7'h78, 7'h30, 7'h30, 7'h46, 7'h46, 7'h0D, 7'h0A};
      for (int k = 0; k < 8; k++)
        if (k < got.size()) chk($sformatf("after_rst_char%0d", k), {25'd0, got[k]}, {25'd0, e[k]});
    end

    // Minimal configuration: 0xE7 -> 'E', '7', then idle.
    m_in_data = 8'hE7; m_in_valid = 1'b1;
    chk("min_in_ready", {31'd0, m_in_ready}, 32'd1);
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    chk("min_char0", {24'd0, m_out_valid, m_out_char}, {24'd0, 1'b1, 7'h45});
    @(posedge clk); #1;
    chk("min_char1", {24'd0, m_out_valid, m_out_char}, {24'd0, 1'b1, 7'h37});
    @(posedge clk); #1;
    chk("min_idle", {29'd0, m_out_valid, m_busy, m_in_ready}, 32'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
